// File: rtl/fpu_ret_collect_pkg.sv
// Shared FP completion definitions: exception flag positions, retire code
// width, unit identifiers and the queued entry layout.
package fpu_ret_collect_pkg;

    localparam int RET_W  = 14;
    localparam int FLAG_W = 5;

    localparam int FPFLAG_NV = 4;
    localparam int FPFLAG_DZ = 3;
    localparam int FPFLAG_OF = 2;
    localparam int FPFLAG_UF = 1;
    localparam int FPFLAG_NX = 0;

    localparam logic [1:0] UID_U1 = 2'd0;
    localparam logic [1:0] UID_U3 = 2'd1;
    localparam logic [1:0] UID_U5 = 2'd2;

    typedef struct packed {
        logic [1:0]       uid;
        logic [RET_W-1:0] ret;
    } ret_entry_t;

    function automatic logic [FLAG_W-1:0] ret_flags(input logic [RET_W-1:0] r);
        return {r[FPFLAG_NV], r[FPFLAG_DZ], r[FPFLAG_OF], r[FPFLAG_UF], r[FPFLAG_NX]};
    endfunction

endpackage

// File: rtl/fpu_ret_collect_if.sv
// Completion bus between the FP SIMD units, the retire logic and the fpcsr;
// master drives retire codes and the drain handshake, slave is the collector.
interface fpu_ret_collect_if;
    import fpu_ret_collect_pkg::*;

    logic [RET_W-1:0]  u1_ret;
    logic              u1_ret_en;
    logic [RET_W-1:0]  u3_ret;
    logic              u3_ret_en;
    logic [RET_W-1:0]  u5_ret;
    logic              u5_ret_en;
    logic [15:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              flag_clr;
    logic [FLAG_W-1:0] flags;
    logic              stall;
    logic              ovf_err;

    modport master (
        output u1_ret, u1_ret_en, u3_ret, u3_ret_en, u5_ret, u5_ret_en,
        output out_ready, flag_clr,
        input  out_data, out_valid, flags, stall, ovf_err
    );

    modport slave (
        input  u1_ret, u1_ret_en, u3_ret, u3_ret_en, u5_ret, u5_ret_en,
        input  out_ready, flag_clr,
        output out_data, out_valid, flags, stall, ovf_err
    );

endinterface

// File: rtl/fpu_ret_compact.sv
// Packs the enabled retire channels (u1, u3, u5 priority) into consecutive
// write slots, clipped to the room left in the queue this cycle.
module fpu_ret_compact
    import fpu_ret_collect_pkg::*;
(
    input  ret_entry_t [2:0] in_entry_i,
    input  logic [2:0]       in_en_i,
    input  logic [1:0]       room_i,
    output ret_entry_t [2:0] slot_data_o,
    output logic [2:0]       slot_we_o,
    output logic [2:0]       accept_o,
    output logic [1:0]       push_cnt_o,
    output logic             drop_o
);

    logic [1:0] idx;

    // Channels beyond the available room are dropped, so u5 loses first.
    always_comb begin
        slot_data_o = '0;
        slot_we_o   = '0;
        accept_o    = '0;
        drop_o      = 1'b0;
        idx         = 2'd0;
        for (int ch = 0; ch < 3; ch++) begin
            if (in_en_i[ch]) begin
                if (idx < room_i) begin
                    slot_data_o[idx] = in_entry_i[ch];
                    slot_we_o[idx]   = 1'b1;
                    accept_o[ch]     = 1'b1;
                    idx              = idx + 2'd1;
                end else begin
                    drop_o = 1'b1;
                end
            end
        end
        push_cnt_o = idx;
    end

endmodule

// File: rtl/fpu_ret_collect.sv
// Completion collector: queues up to three retire codes per cycle, drains one
// per cycle show-ahead, and tracks sticky IEEE flags, overflow and issue stall.
module fpu_ret_collect
    import fpu_ret_collect_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int STALL_THR = 12
) (
    input logic               clk,
    input logic               rst,
    fpu_ret_collect_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ret_entry_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     free_slots;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              stall_q, stall_d;
    logic              ovf_q, ovf_d;

    ret_entry_t [2:0]  in_entry;
    ret_entry_t [2:0]  slot_data;
    logic [2:0]        in_en;
    logic [2:0]        slot_we;
    logic [2:0]        accept;
    logic [1:0]        room;
    logic [1:0]        push_cnt;
    logic              drop;
    logic              pop;

    assign in_entry[0] = ret_entry_t'{uid: UID_U1, ret: bus.u1_ret};
    assign in_entry[1] = ret_entry_t'{uid: UID_U3, ret: bus.u3_ret};
    assign in_entry[2] = ret_entry_t'{uid: UID_U5, ret: bus.u5_ret};
    assign in_en       = {bus.u5_ret_en, bus.u3_ret_en, bus.u1_ret_en};

    // A same-cycle pop frees its slot for this cycle's pushes.
    assign pop        = (count_q != '0) & bus.out_ready;
    assign free_slots = CW'(DEPTH) - count_q + {{(CW-1){1'b0}}, pop};
    assign room       = (free_slots >= CW'(3)) ? 2'd3 : free_slots[1:0];

    fpu_ret_compact u_compact (
        .in_entry_i  (in_entry),
        .in_en_i     (in_en),
        .room_i      (room),
        .slot_data_o (slot_data),
        .slot_we_o   (slot_we),
        .accept_o    (accept),
        .push_cnt_o  (push_cnt),
        .drop_o      (drop)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_cnt);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + {{(CW-2){1'b0}}, push_cnt} - {{(CW-1){1'b0}}, pop};
        flags_d  = bus.flag_clr ? '0 : flags_q;
        for (int ch = 0; ch < 3; ch++) begin
            if (accept[ch]) begin
                flags_d = flags_d | ret_flags(in_entry[ch].ret);
            end
        end
        stall_d  = (CW'(DEPTH) - count_d) < CW'(STALL_THR);
        ovf_d    = ovf_q | drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: count gates everything that reads it.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (slot_we[k]) begin
                mem[wr_ptr_q + AW'(k)] <= slot_data[k];
            end
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr_q] : '0;
    assign bus.flags     = flags_q;
    assign bus.stall     = stall_q;
    assign bus.ovf_err   = ovf_q;

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Scoreboard bench for fpu_ret_collect: directed pushes queue expected entries,
// a negedge monitor checks every drained head against them.
module tb_fpu_ret_collect;
    import fpu_ret_collect_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fpu_ret_collect_if bus ();

    fpu_ret_collect #(.DEPTH(16), .STALL_THR(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] sb [$];
    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of retire traffic; acc marks the channels expected to be accepted.
    task automatic applyStimulus(input logic e1, input logic [13:0] r1,
                                 input logic e3, input logic [13:0] r3,
                                 input logic e5, input logic [13:0] r5,
                                 input logic [2:0] acc, input logic clr);
        bus.u1_ret_en = e1; bus.u1_ret = r1;
        bus.u3_ret_en = e3; bus.u3_ret = r3;
        bus.u5_ret_en = e5; bus.u5_ret = r5;
        bus.flag_clr  = clr;
        if (acc[0]) sb.push_back({UID_U1, r1});
        if (acc[1]) sb.push_back({UID_U3, r3});
        if (acc[2]) sb.push_back({UID_U5, r5});
        @(posedge clk);
        #1;
        bus.u1_ret_en = 1'b0;
        bus.u3_ret_en = 1'b0;
        bus.u5_ret_en = 1'b0;
        bus.flag_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL pop_unexpected: got %h expected no entry", bus.out_data);
            end else begin
                checkOutput("pop_data", bus.out_data, sb.pop_front());
            end
        end
    end

    initial begin
        logic [13:0] r;
        bus.u1_ret = '0; bus.u1_ret_en = 1'b0;
        bus.u3_ret = '0; bus.u3_ret_en = 1'b0;
        bus.u5_ret = '0; bus.u5_ret_en = 1'b0;
        bus.out_ready = 1'b0;
        bus.flag_clr  = 1'b0;

        idle(2);
        checkOutput("rst_valid", 16'(bus.out_valid), 16'h0);
        checkOutput("rst_data",  bus.out_data,       16'h0);
        checkOutput("rst_flags", 16'(bus.flags),     16'h0);
        checkOutput("rst_stall", 16'(bus.stall),     16'h0);
        checkOutput("rst_ovf",   16'(bus.ovf_err),   16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single push, show-ahead head one cycle later
        applyStimulus(0, 14'h0, 1, 14'h0101, 0, 14'h0, 3'b010, 0);
        checkOutput("t1_valid", 16'(bus.out_valid), 16'h1);
        checkOutput("t1_data",  bus.out_data,       16'h4101);
        checkOutput("t1_flags", 16'(bus.flags),     16'h0001);
        bus.out_ready = 1'b1;
        idle(1);
        checkOutput("t1_empty", 16'(bus.out_valid), 16'h0);

        // compaction of u1 and u5 with u3 idle
        applyStimulus(0, 14'h0, 0, 14'h0, 0, 14'h0, 3'b000, 1);
        bus.out_ready = 1'b0;
        applyStimulus(1, 14'h0020, 0, 14'h0, 1, 14'h0048, 3'b101, 0);
        checkOutput("t2_flags", 16'(bus.flags), 16'h0008);
        bus.out_ready = 1'b1;
        idle(2);
        checkOutput("t2_empty", 16'(bus.out_valid), 16'h0);

        // fill to stall and overflow
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1, 14'((c*3+1) << 5), 1, 14'((c*3+2) << 5), 1, 14'((c*3+3) << 5), 3'b111, 0);
            if (c == 0) checkOutput("t3_stall_lo", 16'(bus.stall), 16'h0);
            if (c == 1) checkOutput("t3_stall_hi", 16'(bus.stall), 16'h1);
        end
        checkOutput("t3_ovf_lo", 16'(bus.ovf_err), 16'h0);
        applyStimulus(1, 14'h0220, 1, 14'h0003, 1, 14'h0004, 3'b001, 0);
        checkOutput("t3_ovf_hi", 16'(bus.ovf_err), 16'h1);
        checkOutput("t3_flags",  16'(bus.flags),   16'h0008);

        // full with simultaneous pop: one slot reused, second push dropped
        bus.out_ready = 1'b1;
        applyStimulus(1, 14'h3fe0, 1, 14'h0011, 0, 14'h0, 3'b001, 0);
        checkOutput("t4_flags", 16'(bus.flags), 16'h0008);
        idle(15);
        checkOutput("t4_last_valid", 16'(bus.out_valid), 16'h1);
        idle(1);
        checkOutput("t4_drained", 16'(bus.out_valid), 16'h0);
        checkOutput("t4_sb",      16'(sb.size()),     16'h0);
        checkOutput("t4_stall",   16'(bus.stall),     16'h0);

        // clear racing with a set
        applyStimulus(1, 14'h0010, 0, 14'h0, 0, 14'h0, 3'b001, 1);
        checkOutput("t5_flags_a", 16'(bus.flags), 16'h0010);
        applyStimulus(0, 14'h0, 1, 14'h0002, 0, 14'h0, 3'b010, 1);
        checkOutput("t5_flags_b", 16'(bus.flags), 16'h0002);

        // stream across pointer wraps, then reset mid-stream
        for (int i = 0; i < 40; i++) begin
            r = 14'h1000 + 14'(i);
            case (i % 3)
                0:       applyStimulus(1, r, 0, 14'h0, 0, 14'h0, 3'b001, 0);
                1:       applyStimulus(0, 14'h0, 1, r, 0, 14'h0, 3'b010, 0);
                default: applyStimulus(0, 14'h0, 0, 14'h0, 1, r, 3'b100, 0);
            endcase
        end
        bus.out_ready = 1'b0;
        applyStimulus(1, 14'h2001, 1, 14'h2002, 1, 14'h2003, 3'b111, 0);
        checkOutput("t6_pre_valid", 16'(bus.out_valid), 16'h1);
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        checkOutput("t6_rst_valid", 16'(bus.out_valid), 16'h0);
        checkOutput("t6_rst_data",  bus.out_data,       16'h0);
        checkOutput("t6_rst_flags", 16'(bus.flags),     16'h0);
        checkOutput("t6_rst_stall", 16'(bus.stall),     16'h0);
        checkOutput("t6_rst_ovf",   16'(bus.ovf_err),   16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        applyStimulus(0, 14'h0, 0, 14'h0, 1, 14'h0abc, 3'b100, 0);
        idle(2);
        checkOutput("final_empty", 16'(bus.out_valid), 16'h0);
        checkOutput("final_sb",    16'(sb.size()),     16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
